// File: rtl/fir_pkg.sv
// fir_pkg: shared sizes, FSM states and output saturation for the FIR channel scheduler
package fir_pkg;
  localparam int NCH = 4;
  localparam int WIDTH = 24;
  localparam int TAPS = 128;
  localparam int SHIFT = 16;
  localparam int MAC_LAT = 2;
  localparam int TW = $clog2(TAPS);
  localparam int CW = $clog2(NCH);
  typedef enum logic [2:0] {CLEAR, ARB, WRITE, RUN, DRAIN, OUT} state_t;
  // Result fits only when every bit from the sign down to bit WIDTH-1 agrees
  function automatic logic signed [WIDTH-1:0] sat_width(input logic signed [2*WIDTH-1:0] acc);
    logic signed [2*WIDTH-1:0] s;
    s = acc >>> SHIFT;
    return (&s[2*WIDTH-1:WIDTH-1] || ~|s[2*WIDTH-1:WIDTH-1]) ? s[WIDTH-1:0] : {s[2*WIDTH-1], {(WIDTH-1){~s[2*WIDTH-1]}}};
  endfunction
endpackage

// File: rtl/fir_channel_sched_if.sv
// fir_channel_sched_if: sample, delay/coef address, MAC control and result signals
interface fir_channel_sched_if;
  import fir_pkg::*;
  logic [NCH-1:0] in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0] in_ready;
  logic [TW-1:0] coef_addr;
  logic [CW+TW-1:0] dly_addr;
  logic dly_we;
  logic signed [WIDTH-1:0] dly_wdata;
  logic mac_en;
  logic mac_clr;
  logic signed [2*WIDTH-1:0] acc_in;
  logic out_valid;
  logic [CW-1:0] out_chan;
  logic signed [WIDTH-1:0] out_data;
  logic out_ready;
  modport master (
    input in_valid, in_data, acc_in, out_ready,
    output in_ready, coef_addr, dly_addr, dly_we, dly_wdata, mac_en, mac_clr, out_valid, out_chan, out_data
  );
  modport slave (
    output in_valid, in_data, acc_in, out_ready,
    input in_ready, coef_addr, dly_addr, dly_we, dly_wdata, mac_en, mac_clr, out_valid, out_chan, out_data
  );
endinterface

// File: rtl/fir_rr_arbiter.sv
// fir_rr_arbiter: NCH-way rotating-priority grant starting just after the last winner
module fir_rr_arbiter import fir_pkg::*; (
  input logic [NCH-1:0] req,
  input logic [CW-1:0] last,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0] idx
);
  // Scan farthest to nearest so the nearest requester after last wins
  always_comb begin
    idx = '0;
    for (int i = NCH; i >= 1; i--)
      if (req[CW'(int'(last) + i)]) idx = CW'(int'(last) + i);
    grant = |req ? NCH'(1) << idx : '0;
  end
endmodule

// File: rtl/fir_channel_sched.sv
// fir_channel_sched: round-robin sequencer sharing one FIR MAC datapath between NCH channels
module fir_channel_sched import fir_pkg::*; (
  input logic clk,
  input logic rst,
  fir_channel_sched_if.master bus
);
  state_t state, state_n;
  logic [CW+TW-1:0] cnt;
  logic [CW-1:0] chan, last_grant, gidx;
  logic [NCH-1:0] gnt;
  logic [WIDTH-1:0] sample;
  logic [TW-1:0] wptr [NCH];
  logic signed [WIDTH-1:0] res;
  fir_rr_arbiter u_arb (.req(bus.in_valid), .last(last_grant), .grant(gnt), .idx(gidx));
  // cnt doubles as clear address, tap index and drain timer; it restarts on every state change
  always_comb begin
    state_n = state;
    case (state)
      CLEAR: if (&cnt) state_n = ARB;
      ARB: if (|bus.in_valid) state_n = WRITE;
      WRITE: state_n = RUN;
      RUN: if (&cnt[TW-1:0]) state_n = DRAIN;
      DRAIN: if (cnt == (CW+TW)'(MAC_LAT-1)) state_n = OUT;
      OUT: if (bus.out_ready) state_n = ARB;
      default: state_n = CLEAR;
    endcase
    bus.in_ready = state == ARB ? gnt : '0;
    bus.coef_addr = state == RUN ? cnt[TW-1:0] : '0;
    bus.dly_addr = state == CLEAR ? cnt : state == WRITE ? {chan, wptr[chan]} : state == RUN ? {chan, wptr[chan] - cnt[TW-1:0]} : '0;
    bus.dly_we = state inside {CLEAR, WRITE};
    bus.dly_wdata = state == WRITE ? sample : '0;
    bus.mac_en = state == RUN;
    bus.mac_clr = state == RUN && cnt[TW-1:0] == '0;
    bus.out_valid = state == OUT;
    bus.out_chan = state == OUT ? chan : '0;
    bus.out_data = state == OUT ? res : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      chan <= '0;
      last_grant <= CW'(NCH-1);
      sample <= '0;
      res <= '0;
      wptr <= '{default: '0};
    end else begin
      state <= state_n;
      cnt <= state_n == state ? cnt + 1'b1 : '0;
      if (state == ARB && |bus.in_valid) begin
        chan <= gidx;
        sample <= bus.in_data[gidx*WIDTH +: WIDTH];
      end
      if (state == RUN && &cnt[TW-1:0]) wptr[chan] <= wptr[chan] + 1'b1;
      if (state == DRAIN && state_n == OUT) res <= sat_width(bus.acc_in);
      if (state == OUT && bus.out_ready) last_grant <= chan;
    end
  end
endmodule

// File: tb/tb_fir_channel_sched.sv
// tb_fir_channel_sched: random multi-channel stimulus scored against a convolution reference model
module tb_fir_channel_sched;
  import fir_pkg::*;
  typedef struct { int chan; logic signed [WIDTH-1:0] data; longint hs; } exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  fir_channel_sched_if bus();
  fir_channel_sched dut (.clk(clk), .rst(rst), .bus(bus));
  int compared = 0, mismatched = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction
  function automatic int coef(input int k);
    return k == 0 ? 10 : k == 1 ? 18 : k == 2 ? 19 : (k * 37) % 41 - 20;
  endfunction
  // Environment: delay RAM, coefficient ROM and a MAC_LAT-deep multiply-accumulate pipe
  logic signed [WIDTH-1:0] ram [NCH*TAPS];
  longint p1 = 0, acc = 0;
  logic en1 = 0, clr1 = 0;
  int sat_mode = 0;
  always @(posedge clk) begin
    if (bus.dly_we) ram[bus.dly_addr] <= bus.dly_wdata;
    p1 <= longint'(coef(int'(bus.coef_addr))) * longint'(ram[bus.dly_addr]);
    en1 <= bus.mac_en;
    clr1 <= bus.mac_clr;
    if (en1) acc <= clr1 ? p1 : acc + p1;
  end
  assign bus.acc_in = sat_mode == 1 ? 48'sh7FFFFFFFFFFF : sat_mode == 2 ? 48'sh800000000000 : acc[47:0];
  logic rand_bp = 0, bp_rand = 1, ready_set = 1;
  assign bus.out_ready = rand_bp ? bp_rand : ready_set;
  initial forever begin
    @(posedge clk);
    #1 bp_rand = 1'($urandom_range(0, 1));
  end
  // Reference model: per-channel sample history, y = sat((sum coef[k]*x[n-k]) >>> SHIFT)
  longint hist [NCH][TAPS];
  int nsamp [NCH];
  int last_g = NCH - 1;
  exp_t sbq[$];
  int glog[$];
  function automatic logic signed [WIDTH-1:0] ref_out(input int c);
    longint s;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(coef(k)) * hist[c][k];
    s = s >>> SHIFT;
    return s > (longint'(1) <<< (WIDTH-1)) - 1 ? 24'sh7FFFFF : s < -(longint'(1) <<< (WIDTH-1)) ? 24'sh800000 : WIDTH'(s);
  endfunction
  int hs_cnt = 0, hs_chan = 0, run_chan = 0, g, wr_addr;
  logic wr_pend = 0;
  logic signed [WIDTH-1:0] smp, wr_data;
  exp_t ein, eout;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sbq.delete();
      last_g = NCH - 1;
      wr_pend = 0;
      for (int c = 0; c < NCH; c++) begin
        nsamp[c] = 0;
        for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
      end
    end else begin
      if (wr_pend) begin
        chk("write_we", bus.dly_we, 1);
        chk("write_addr", bus.dly_addr, wr_addr);
        chk("write_data", bus.dly_wdata, wr_data);
        wr_pend = 0;
      end
      if (bus.mac_en) chk("run_bank", longint'(bus.dly_addr) / TAPS, run_chan);
      if (|(bus.in_valid & bus.in_ready)) begin
        g = -1;
        for (int i = 1; i <= NCH; i++) if (g < 0 && bus.in_valid[(last_g + i) % NCH]) g = (last_g + i) % NCH;
        chk("grant", bus.in_ready, longint'(1) << g);
        for (int i = 0; i < NCH; i++) if (bus.in_ready[i]) hs_chan = i;
        glog.push_back(hs_chan);
        smp = bus.in_data[g*WIDTH +: WIDTH];
        for (int k = TAPS - 1; k > 0; k--) hist[g][k] = hist[g][k-1];
        hist[g][0] = smp;
        wr_addr = g * TAPS + nsamp[g] % TAPS;
        wr_data = smp;
        wr_pend = 1;
        nsamp[g]++;
        ein.chan = g;
        ein.data = sat_mode == 1 ? 24'sh7FFFFF : sat_mode == 2 ? 24'sh800000 : ref_out(g);
        ein.hs = cyc;
        sbq.push_back(ein);
        run_chan = g;
        last_g = g;
        hs_cnt++;
      end
    end
  end
  logic prev_ov = 0;
  initial forever begin
    @(negedge clk);
    if (rst) prev_ov = 0;
    else begin
      if (bus.out_valid && !prev_ov && sbq.size() != 0) chk("latency", cyc - sbq[0].hs, 2 + TAPS + MAC_LAT);
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL out_unexpected: got result chan %0d data %0d, expected none", bus.out_chan, bus.out_data);
        end else begin
          eout = sbq.pop_front();
          chk("out_chan", bus.out_chan, eout.chan);
          chk("out_data", bus.out_data, eout.data);
        end
      end
      prev_ov = bus.out_valid;
    end
  end
  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got timeout, expected event", name);
  endtask
  task automatic wait_next();
    int n = hs_cnt;
    int t = 0;
    while (hs_cnt == n && t < 2000) begin
      @(posedge clk);
      #1 t++;
    end
    if (hs_cnt == n) timeout("handshake");
  endtask
  task automatic send1(input int c, input logic [WIDTH-1:0] d);
    bus.in_data[c*WIDTH +: WIDTH] = d;
    bus.in_valid[c] = 1;
    wait_next();
    bus.in_valid[c] = 0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((sbq.size() != 0 || bus.out_valid) && t < 3000) begin
      @(posedge clk);
      #1 t++;
    end
    if (t >= 3000) timeout("drain");
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < NCH * TAPS; i++) begin
      @(negedge clk);
      chk("clear_we", bus.dly_we, 1);
      chk("clear_addr", bus.dly_addr, i);
      chk("clear_wdata", bus.dly_wdata, 0);
      chk("clear_in_ready", bus.in_ready, 0);
      chk("clear_out_valid", bus.out_valid, 0);
      chk("clear_mac_en", bus.mac_en, 0);
      @(posedge clk);
      #1;
    end
  endtask
  logic [NCH-1:0] m;
  logic signed [WIDTH-1:0] d0;
  logic [CW-1:0] c0;
  initial begin
    bus.in_valid = '0;
    bus.in_data = '0;
    do_reset();
    send1(0, 24'h010000);
    for (int i = 0; i < 5; i++) send1(0, 24'h0);
    wait_idle();
    do_reset();
    for (int c = 0; c < NCH; c++) bus.in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
    glog.delete();
    bus.in_valid = '1;
    for (int i = 0; i < 5; i++) begin
      wait_next();
      bus.in_data[hs_chan*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    bus.in_valid = '0;
    if (glog.size() < 5) timeout("grant_log");
    else for (int i = 0; i < 5; i++) chk("rr_order", glog[i], i % NCH);
    wait_idle();
    send1(2, WIDTH'($urandom));
    bus.in_valid = '1;
    wait_next();
    bus.in_valid = '0;
    chk("rr_after_ch2", hs_chan, 3);
    wait_idle();
    rand_bp = 1;
    for (int i = 0; i < 30; i++) begin
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int c = 0; c < NCH; c++) if (m[c] && !bus.in_valid[c]) bus.in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      bus.in_valid = bus.in_valid | m;
      wait_next();
      bus.in_valid[hs_chan] = 0;
    end
    bus.in_valid = '0;
    rand_bp = 0;
    wait_idle();
    ready_set = 0;
    send1(1, WIDTH'($urandom));
    for (int t = 0; t < 400 && !bus.out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    d0 = bus.out_data;
    c0 = bus.out_chan;
    bus.in_data[3*WIDTH +: WIDTH] = WIDTH'($urandom);
    bus.in_valid[3] = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", bus.out_data, d0);
      chk("bp_out_chan", bus.out_chan, c0);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    ready_set = 1;
    @(posedge clk);
    #1 chk("release_arb", bus.in_ready, 4'b1000);
    wait_next();
    bus.in_valid[3] = 0;
    wait_idle();
    sat_mode = 1;
    send1(0, WIDTH'($urandom));
    wait_idle();
    sat_mode = 2;
    send1(3, WIDTH'($urandom));
    wait_idle();
    sat_mode = 0;
    for (int i = 0; i < 130; i++) send1(2, WIDTH'($urandom));
    send1(2, WIDTH'($urandom));
    repeat (51) @(posedge clk);
    #1;
    chk("k50_mac_en", bus.mac_en, 1);
    chk("k50_coef_addr", bus.coef_addr, 50);
    do_reset();
    send1(2, WIDTH'($urandom));
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end
endmodule
